// File: rtl/univ_rotate_reg_pkg.sv
// -----------------------------------------------------------------------------
// univ_rotate_reg_pkg
//   Shared definitions for the universal rotate register.
//   CTRL_* : encodings of the 2-bit operation select presented on ctrl.
// -----------------------------------------------------------------------------
package univ_rotate_reg_pkg;

    localparam logic [1:0] CTRL_LOAD = 2'b00;   // q <= data
    localparam logic [1:0] CTRL_ROR  = 2'b01;   // rotate right, LSB wraps to MSB
    localparam logic [1:0] CTRL_ROL  = 2'b10;   // rotate left, MSB wraps to bit 0
    localparam logic [1:0] CTRL_HOLD = 2'b11;   // q <= q

endpackage : univ_rotate_reg_pkg

// File: rtl/univ_rotate_reg.sv
// -----------------------------------------------------------------------------
// univ_rotate_reg
//   Universal rotate register: parallel load, rotate left, rotate right or hold,
//   selected each clock by ctrl. Bits leaving one end re-enter at the other end.
//
// Parameters
//   DW        register width in bits (DW >= 1)
//
// Ports
//   clk       in   1    clock, state updates on rising edge
//   sync_rst  in   1    asynchronous active-high reset, clears q immediately
//   ctrl      in   2    operation select (see univ_rotate_reg_pkg)
//   data      in   DW   parallel load value, used only when ctrl selects load
//   q         out  DW   register contents, straight from the state flops
// -----------------------------------------------------------------------------
module univ_rotate_reg
    import univ_rotate_reg_pkg::*;
#(
    parameter int DW = 4
) (
    input  logic          clk,
    input  logic          sync_rst,
    input  logic [1:0]    ctrl,
    input  logic [DW-1:0] data,
    output logic [DW-1:0] q
);

    logic [DW-1:0] r_q;
    logic [DW-1:0] w_rol;
    logic [DW-1:0] w_ror;
    logic [DW-1:0] w_next;

    // A 1-bit register rotates onto itself; the wide slices below would be
    // illegal for DW=1, so that width gets its own branch.
    generate
        if (DW == 1) begin : g_rot_w1
            assign w_rol = r_q;
            assign w_ror = r_q;
        end else begin : g_rot_wn
            assign w_rol = {r_q[DW-2:0], r_q[DW-1]};
            assign w_ror = {r_q[0], r_q[DW-1:1]};
        end
    endgenerate

    // Next-state select: 4:1 mux on the operation code.
    always_comb begin
        w_next = r_q;
        case (ctrl)
            CTRL_LOAD: w_next = data;
            CTRL_ROR:  w_next = w_ror;
            CTRL_ROL:  w_next = w_rol;
            CTRL_HOLD: w_next = r_q;
            default:   w_next = r_q;
        endcase
    end

    // State register with asynchronous clear.
    always_ff @(posedge clk or posedge sync_rst) begin
        if (sync_rst) begin
            r_q <= {DW{1'b0}};
        end else begin
            r_q <= w_next;
        end
    end

    assign q = r_q;

endmodule : univ_rotate_reg

// File: tb/tb_univ_rotate_reg.sv
// -----------------------------------------------------------------------------
// tb_univ_rotate_reg
//   Self-checking bench for univ_rotate_reg: a DW=4 instance driven from a
//   vector table, hand sequences and random stimulus, plus a DW=1 instance.
// -----------------------------------------------------------------------------
module tb_univ_rotate_reg;

    logic       clk;
    logic       sync_rst;
    logic [1:0] ctrl;
    logic [3:0] data;
    logic [3:0] q;

    logic [1:0] ctrl1;
    logic [0:0] data1;
    logic [0:0] q1;

    int total;
    int bad;

    typedef struct {
        logic [1:0] c;
        logic [3:0] d;
        logic [3:0] e;
    } vec_t;

    vec_t tbl[$];

    univ_rotate_reg #(.DW(4)) dut (
        .clk      (clk),
        .sync_rst (sync_rst),
        .ctrl     (ctrl),
        .data     (data),
        .q        (q)
    );

    univ_rotate_reg #(.DW(1)) dut1 (
        .clk      (clk),
        .sync_rst (sync_rst),
        .ctrl     (ctrl1),
        .data     (data1),
        .q        (q1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [3:0] act, input logic [3:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    // Present inputs (called just after a falling edge), pass one rising edge,
    // return at the next falling edge where q is sampled.
    task automatic step(input logic [1:0] c, input logic [3:0] d);
        ctrl = c;
        data = d;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Reference rotate using plain arithmetic on a 4-bit value.
    function automatic int model4(input int cur, input logic [1:0] c, input int d);
        case (c)
            2'b00:   return d;
            2'b10:   return (cur * 2) % 16 + cur / 8;
            2'b01:   return cur / 2 + (cur % 2) * 8;
            default: return cur;
        endcase
    endfunction

    initial begin
        int exp4;
        int exp1;
        total    = 0;
        bad      = 0;
        sync_rst = 1'b1;
        ctrl     = 2'b00;
        data     = 4'b1011;
        ctrl1    = 2'b11;
        data1    = 1'b1;

        // Reset at t=0, q clear before any edge.
        #2;
        check("reset_pre_edge", q, 4'b0000);
        check("reset_pre_edge_w1", {3'b000, q1}, 4'b0000);
        @(negedge clk);
        check("reset_through_edge", q, 4'b0000);
        sync_rst = 1'b0;

        // Tests 1-3 as a vector table.
        tbl.push_back('{2'b00, 4'b1011, 4'b1011});
        tbl.push_back('{2'b10, 4'b0000, 4'b0111});
        tbl.push_back('{2'b10, 4'b1111, 4'b1110});
        tbl.push_back('{2'b11, 4'b0000, 4'b1110});
        tbl.push_back('{2'b11, 4'b0101, 4'b1110});
        tbl.push_back('{2'b10, 4'b0000, 4'b1101});
        tbl.push_back('{2'b10, 4'b0110, 4'b1011});
        tbl.push_back('{2'b00, 4'b1011, 4'b1011});
        tbl.push_back('{2'b01, 4'b0000, 4'b1101});
        tbl.push_back('{2'b01, 4'b1001, 4'b1110});
        tbl.push_back('{2'b11, 4'b0000, 4'b1110});
        tbl.push_back('{2'b11, 4'b0011, 4'b1110});
        tbl.push_back('{2'b01, 4'b0000, 4'b0111});
        tbl.push_back('{2'b11, 4'b1000, 4'b0111});
        tbl.push_back('{2'b10, 4'b0000, 4'b1110});
        tbl.push_back('{2'b11, 4'b0001, 4'b1110});
        tbl.push_back('{2'b01, 4'b0000, 4'b0111});
        tbl.push_back('{2'b11, 4'b1111, 4'b0111});
        foreach (tbl[i]) begin
            step(tbl[i].c, tbl[i].d);
            check($sformatf("vec%0d", i), q, tbl[i].e);
        end

        // Random stimulus against the reference model, both widths.
        exp4 = 7;
        exp1 = 0;
        for (int n = 0; n < 300; n++) begin
            logic [1:0] rc;
            logic [3:0] rd;
            logic [1:0] rc1;
            logic       rd1;
            rc  = 2'($urandom_range(0, 3));
            rd  = 4'($urandom);
            rc1 = 2'($urandom_range(0, 3));
            rd1 = 1'($urandom);
            ctrl1 = rc1;
            data1 = rd1;
            step(rc, rd);
            exp4 = model4(exp4, rc, int'(rd));
            if (rc1 == 2'b00) exp1 = int'(rd1);
            check("random_w4", q, 4'(exp4));
            check("random_w1", {3'b000, q1}, 4'(exp1));
        end

        // Asynchronous reset mid-cycle with q=1110.
        step(2'b00, 4'b1110);
        check("pre_async_load", q, 4'b1110);
        #2;
        sync_rst = 1'b1;
        #1;
        check("async_clear_no_edge", q, 4'b0000);
        @(negedge clk);
        for (int c = 0; c < 4; c++) begin
            step(2'(c), 4'b1111);
            check($sformatf("reset_hold_ctrl%0d", c), q, 4'b0000);
        end
        sync_rst = 1'b0;
        step(2'b00, 4'b0101);
        check("post_reset_load", q, 4'b0101);
        step(2'b10, 4'b0000);
        check("post_reset_rol", q, 4'b1010);

        // DW=1: rotates act as hold.
        ctrl1 = 2'b00; data1 = 1'b1;
        step(2'b11, 4'b0000);
        check("w1_load1", {3'b000, q1}, 4'b0001);
        ctrl1 = 2'b10; data1 = 1'b0;
        step(2'b11, 4'b0000);
        check("w1_rol", {3'b000, q1}, 4'b0001);
        ctrl1 = 2'b01; data1 = 1'b0;
        step(2'b11, 4'b0000);
        check("w1_ror", {3'b000, q1}, 4'b0001);
        ctrl1 = 2'b00; data1 = 1'b0;
        step(2'b11, 4'b0000);
        check("w1_load0", {3'b000, q1}, 4'b0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_univ_rotate_reg
